// File: rtl/mem_arbiter.sv
// Shares one memory port between dcache and icache, tracks which client owns
// each outstanding load tag, and routes memory responses back to that owner.
module mem_arbiter #(
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_transaction_tag,
    input  logic [63:0]                 mem2proc_data,
    input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_data_tag,
    output logic [1:0]                  proc2mem_command,
    output logic [31:0]                 proc2mem_addr,
    output logic [63:0]                 proc2mem_data,
    input  logic [1:0]                  proc2Dmem_command,
    input  logic [31:0]                 proc2Dmem_addr,
    input  logic [63:0]                 proc2Dmem_data,
    output logic [$clog2(NUM_TAGS)-1:0] Dmem2proc_transaction_tag,
    output logic [63:0]                 Dmem2proc_data,
    output logic [$clog2(NUM_TAGS)-1:0] Dmem2proc_data_tag,
    input  logic [1:0]                  proc2Imem_command,
    input  logic [31:0]                 proc2Imem_addr,
    output logic [$clog2(NUM_TAGS)-1:0] Imem2proc_transaction_tag,
    output logic [63:0]                 Imem2proc_data,
    output logic [$clog2(NUM_TAGS)-1:0] Imem2proc_data_tag,
    output logic                        dcache_request,
    output logic                        tag_error
);

    localparam int          TAG_W      = $clog2(NUM_TAGS);
    localparam logic [1:0]  MEM_NONE   = 2'd0;
    localparam logic [1:0]  MEM_LOAD   = 2'd1;
    localparam logic [2:0]  STARVE_MAX = 3'(STARVE_LIMIT);

    logic [NUM_TAGS-1:0] valid_r;
    logic [NUM_TAGS-1:0] owner_r;      // 1 = icache, 0 = dcache
    logic [2:0]          starve_cnt_r;
    logic                tag_error_r;

    logic d_req_s;
    logic i_req_s;
    logic i_win_s;
    logic d_win_s;
    logic load_accept_s;
    logic resp_hit_s;
    logic resp_miss_s;

    // Same-cycle arbitration, command mux and response routing on the pre-edge table
    always_comb begin
        d_req_s                   = 1'b0;
        i_req_s                   = 1'b0;
        i_win_s                   = 1'b0;
        d_win_s                   = 1'b0;
        load_accept_s             = 1'b0;
        resp_hit_s                = 1'b0;
        resp_miss_s               = 1'b0;
        proc2mem_command          = MEM_NONE;
        proc2mem_addr             = 32'd0;
        proc2mem_data             = 64'd0;
        Dmem2proc_transaction_tag = '0;
        Imem2proc_transaction_tag = '0;
        Dmem2proc_data            = 64'd0;
        Imem2proc_data            = 64'd0;
        Dmem2proc_data_tag        = '0;
        Imem2proc_data_tag        = '0;
        dcache_request            = 1'b0;
        if (reset) begin
            proc2mem_command = MEM_NONE;
        end else begin
            d_req_s        = (proc2Dmem_command != MEM_NONE);
            i_req_s        = (proc2Imem_command != MEM_NONE);
            i_win_s        = i_req_s && (!d_req_s || (starve_cnt_r == STARVE_MAX));
            d_win_s        = d_req_s && !i_win_s;
            dcache_request = d_req_s;
            if (i_win_s) begin
                proc2mem_command          = proc2Imem_command;
                proc2mem_addr             = proc2Imem_addr;
                Imem2proc_transaction_tag = mem2proc_transaction_tag;
            end else if (d_win_s) begin
                proc2mem_command          = proc2Dmem_command;
                proc2mem_addr             = proc2Dmem_addr;
                proc2mem_data             = proc2Dmem_data;
                Dmem2proc_transaction_tag = mem2proc_transaction_tag;
            end else begin
                proc2mem_command = MEM_NONE;
            end
            load_accept_s  = (i_win_s || d_win_s) && (proc2mem_command == MEM_LOAD)
                             && (mem2proc_transaction_tag != {TAG_W{1'b0}});
            // Data is broadcast; only the tag qualifies who consumes it
            Dmem2proc_data = mem2proc_data;
            Imem2proc_data = mem2proc_data;
            if (mem2proc_data_tag != {TAG_W{1'b0}}) begin
                if (valid_r[mem2proc_data_tag]) begin
                    resp_hit_s = 1'b1;
                    if (owner_r[mem2proc_data_tag]) begin
                        Imem2proc_data_tag = mem2proc_data_tag;
                    end else begin
                        Dmem2proc_data_tag = mem2proc_data_tag;
                    end
                end else begin
                    resp_miss_s = 1'b1;
                end
            end else begin
                resp_hit_s = 1'b0;
            end
        end
    end

    // Owner table, starvation counter and sticky tag error
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r      <= '0;
            owner_r      <= '0;
            starve_cnt_r <= 3'd0;
            tag_error_r  <= 1'b0;
        end else begin
            if (resp_hit_s) begin
                valid_r[mem2proc_data_tag] <= 1'b0;
            end
            // A grant of the same tag is written last so it overrides the clear
            if (load_accept_s) begin
                valid_r[mem2proc_transaction_tag] <= 1'b1;
                owner_r[mem2proc_transaction_tag] <= i_win_s;
            end
            if (resp_miss_s) begin
                tag_error_r <= 1'b1;
            end
            if (i_win_s && (mem2proc_transaction_tag != {TAG_W{1'b0}})) begin
                starve_cnt_r <= 3'd0;
            end else if (i_req_s && (starve_cnt_r != STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + 3'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end
    end

    assign tag_error = tag_error_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a stimulus process predicts each cycle's
// outputs from a tag-ownership model, a monitor compares them mid-cycle.
module tb_mem_arbiter;

    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mem_ttag = 4'd0;
    logic [63:0] mem_rdata = 64'd0;
    logic [3:0]  mem_rtag = 4'd0;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [1:0]  d_cmd = 2'd0;
    logic [31:0] d_addr = 32'd0;
    logic [63:0] d_wdata = 64'd0;
    logic [3:0]  d_ttag;
    logic [63:0] d_rdata;
    logic [3:0]  d_rtag;
    logic [1:0]  i_cmd = 2'd0;
    logic [31:0] i_addr = 32'd0;
    logic [3:0]  i_ttag;
    logic [63:0] i_rdata;
    logic [3:0]  i_rtag;
    logic        dreq;
    logic        terr;

    mem_arbiter dut (
        .clock                     (clock),
        .reset                     (reset),
        .mem2proc_transaction_tag  (mem_ttag),
        .mem2proc_data             (mem_rdata),
        .mem2proc_data_tag         (mem_rtag),
        .proc2mem_command          (mem_cmd),
        .proc2mem_addr             (mem_addr),
        .proc2mem_data             (mem_wdata),
        .proc2Dmem_command         (d_cmd),
        .proc2Dmem_addr            (d_addr),
        .proc2Dmem_data            (d_wdata),
        .Dmem2proc_transaction_tag (d_ttag),
        .Dmem2proc_data            (d_rdata),
        .Dmem2proc_data_tag        (d_rtag),
        .proc2Imem_command         (i_cmd),
        .proc2Imem_addr            (i_addr),
        .Imem2proc_transaction_tag (i_ttag),
        .Imem2proc_data            (i_rdata),
        .Imem2proc_data_tag        (i_rtag),
        .dcache_request            (dreq),
        .tag_error                 (terr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  dtag;
        logic [3:0]  itag;
        logic [3:0]  drt;
        logic [3:0]  irt;
        logic [63:0] rdata;
        logic        dreq;
        logic        te;
        logic        chk_te;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: who owns each tag (-1 none, 0 dcache, 1 icache)
    int owner_m[16];
    int starve_m = 0;
    bit te_m = 1'b0;
    bit te_known = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input logic rst, input logic [1:0] dc, input logic [31:0] da,
                       input logic [63:0] dd, input logic [1:0] ic, input logic [31:0] ia,
                       input logic [3:0] mt, input logic [3:0] rt, input logic [63:0] rd);
        exp_t e;
        bit dr, ir, iw, dw;
        @(posedge clock);
        #1;
        reset = rst; d_cmd = dc; d_addr = da; d_wdata = dd; i_cmd = ic; i_addr = ia;
        mem_ttag = mt; mem_rtag = rt; mem_rdata = rd;
        e = '{cmd: NONE, addr: 32'd0, wdata: 64'd0, dtag: 4'd0, itag: 4'd0, drt: 4'd0,
              irt: 4'd0, rdata: 64'd0, dreq: 1'b0, te: te_m, chk_te: te_known};
        if (rst) begin
            for (int i = 0; i < 16; i++) owner_m[i] = -1;
            starve_m = 0; te_m = 1'b0; te_known = 1'b1;
        end else begin
            dr = (dc != NONE);
            ir = (ic != NONE);
            iw = ir && (!dr || starve_m == 4);
            dw = dr && !iw;
            e.dreq = dr;
            if (iw) begin e.cmd = ic; e.addr = ia; e.itag = mt; end
            if (dw) begin e.cmd = dc; e.addr = da; e.wdata = dd; e.dtag = mt; end
            e.rdata = rd;
            if (rt != 4'd0) begin
                if (owner_m[rt] == 0) e.drt = rt;
                else if (owner_m[rt] == 1) e.irt = rt;
                else te_m = 1'b1;
                owner_m[rt] = -1;
            end
            if ((iw || dw) && e.cmd == LOAD && mt != 4'd0) owner_m[mt] = iw ? 1 : 0;
            if (iw && mt != 4'd0) starve_m = 0;
            else if (ir && starve_m < 4) starve_m++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd0, 64'd0);
    endtask

    // Monitor: compare mid-cycle whenever a prediction is pending
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_cmd",   64'(mem_cmd),   64'(e.cmd));
            chk("mem_addr",  64'(mem_addr),  64'(e.addr));
            chk("mem_wdata", mem_wdata,      e.wdata);
            chk("d_ttag",    64'(d_ttag),    64'(e.dtag));
            chk("i_ttag",    64'(i_ttag),    64'(e.itag));
            chk("d_rtag",    64'(d_rtag),    64'(e.drt));
            chk("i_rtag",    64'(i_rtag),    64'(e.irt));
            chk("d_rdata",   d_rdata,        e.rdata);
            chk("i_rdata",   i_rdata,        e.rdata);
            chk("dcache_request", 64'(dreq), 64'(e.dreq));
            if (e.chk_te) chk("tag_error", 64'(terr), 64'(e.te));
        end
    end

    initial begin
        bit r;
        logic [1:0] dc;
        for (int i = 0; i < 16; i++) owner_m[i] = -1;
        cyc(1'b1, LOAD, 32'h10, 64'h5, LOAD, 32'h20, 4'd9, 4'd3, 64'h77);
        cyc(1'b1, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd0, 64'd0);
        // dcache load tag 3, then its response
        cyc(1'b0, LOAD, 32'h100, 64'd0, NONE, 32'd0, 4'd3, 4'd0, 64'd0);
        idle(1);
        cyc(1'b0, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd3, 64'hAB);
        // both request every cycle: icache forced through on the fifth
        for (int k = 0; k < 5; k++)
            cyc(1'b0, LOAD, 32'h300 + 32'(k), 64'd0, LOAD, 32'h400, 4'd5, 4'd0, 64'd0);
        cyc(1'b0, LOAD, 32'h308, 64'd0, LOAD, 32'h400, 4'd6, 4'd5, 64'h55);
        cyc(1'b0, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd6, 64'h66);
        // store is not recorded; its tag later raises a sticky error
        cyc(1'b0, STORE, 32'h200, 64'hFF, NONE, 32'd0, 4'd7, 4'd0, 64'd0);
        idle(1);
        cyc(1'b0, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd7, 64'h1);
        idle(2);
        // response and re-grant of tag 2 in the same cycle
        cyc(1'b0, NONE, 32'd0, 64'd0, LOAD, 32'h500, 4'd2, 4'd0, 64'd0);
        cyc(1'b0, LOAD, 32'h600, 64'd0, NONE, 32'd0, 4'd2, 4'd2, 64'h22);
        cyc(1'b0, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd2, 64'h23);
        // memory rejects an icache load
        cyc(1'b0, NONE, 32'd0, 64'd0, LOAD, 32'h700, 4'd0, 4'd0, 64'd0);
        cyc(1'b0, NONE, 32'd0, 64'd0, LOAD, 32'h700, 4'd8, 4'd0, 64'd0);
        // reset with tags outstanding discards ownership
        cyc(1'b0, LOAD, 32'h800, 64'd0, NONE, 32'd0, 4'd1, 4'd0, 64'd0);
        cyc(1'b0, NONE, 32'd0, 64'd0, LOAD, 32'h900, 4'd4, 4'd0, 64'd0);
        cyc(1'b1, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd0, 64'd0);
        cyc(1'b0, NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, 4'd4, 64'h44);
        idle(1);
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 63) == 0);
            dc = 2'($urandom_range(0, 2));
            cyc(r, dc, $urandom, {$urandom, $urandom},
                2'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                {$urandom, $urandom});
        end
        idle(1);
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
